// File: rtl/nn_pkg.sv
// Shared constants for the image front end, network and display path.
// Also carries the UART bit-FSM state type.
package nn_pkg;

    localparam int NN_NUM_PIXELS   = 784;
    localparam int NN_PIX_W        = 8;
    localparam int NN_ADDR_W       = 10;
    localparam int NN_CLKS_PER_BIT = 434;        // 50 MHz / 115200 baud
    localparam int NN_IDLE_TIMEOUT = 5_000_000;  // 100 ms at 50 MHz

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and stop-bit check.
// byte_valid is a one-cycle strobe with no back-pressure; rx_byte holds the byte while it is high.
module uart_rx
    import nn_pkg::*;
#(
    parameter int CLKS_PER_BIT = NN_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1;
    logic             rx_line;
    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;

    // Synchronizer flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1   <= 1'b1;
            rx_line <= 1'b1;
        end else begin
            sync1   <= rx_serial;
            rx_line <= sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= RX_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!rx_line) state <= RX_START;
                end
                RX_START: begin
                    // Re-check the start bit at its middle; a high line here was a glitch.
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        rx_byte  <= {rx_line, rx_byte[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt    <= '0;
                        state       <= RX_IDLE;
                        byte_valid  <= rx_line;
                        frame_error <= !rx_line;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_image_loader.sv
// UART image loader: fills a pixel frame buffer from the serial stream and
// hands the complete frame to the network through a ready/ack handshake.
module uart_image_loader
    import nn_pkg::*;
#(
    parameter int CLKS_PER_BIT = NN_CLKS_PER_BIT,
    parameter int NUM_PIXELS   = NN_NUM_PIXELS,
    parameter int ADDR_W       = NN_ADDR_W,
    parameter int PIX_W        = NN_PIX_W,
    parameter int IDLE_TIMEOUT = NN_IDLE_TIMEOUT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_serial,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] pix_count,
    output logic              frame_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(IDLE_TIMEOUT - 1);

    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              frame_error;
    logic [PIX_W-1:0]  mem [0:DEPTH-1];
    logic [TO_W-1:0]   idle_cnt;
    logic              ack_now;
    logic              accept;
    logic              timeout;
    logic [ADDR_W-1:0] count_base;
    logic              err_base;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .rx_serial  (rx_serial),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_error(frame_error)
    );

    assign busy = (pix_count != '0) && !frame_ready;

    // An ack is applied before a coincident byte, so that byte opens the next frame.
    always_comb begin
        ack_now    = frame_ack && frame_ready;
        accept     = byte_valid && (!frame_ready || ack_now);
        count_base = ack_now ? '0 : pix_count;
        err_base   = ack_now ? 1'b0 : frame_err;
        timeout    = busy && !byte_valid && (idle_cnt == TO_LAST);
    end

    // Write and read ports kept in plain form so the buffer maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) mem[count_base] <= PIX_W'(rx_byte);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rd_data <= '0;
        else         rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_count   <= '0;
            frame_ready <= 1'b0;
            frame_err   <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            if (accept) begin
                pix_count   <= count_base + ADDR_W'(1);
                frame_ready <= (count_base == LAST_ADDR);
            end else begin
                pix_count   <= timeout ? '0 : count_base;
                frame_ready <= frame_ready && !ack_now;
            end

            if (frame_error)  frame_err <= 1'b1;
            else if (timeout) frame_err <= 1'b0;
            else              frame_err <= err_base;

            // Silence timer only runs while a partial frame is pending.
            if (byte_valid || !busy || timeout) idle_cnt <= '0;
            else                                idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader with an event-driven frame model and literal spot checks.
module tb_uart_image_loader;

    localparam int CPB  = 8;
    localparam int N    = 260;
    localparam int AW   = 9;
    localparam int PW   = 8;
    localparam int T    = 1000;
    localparam int HALF = CPB / 2;
    // Pin to write edge: 2 sync flops, 1 edge detect, half start bit, 8 data bits, stop bit, write edge.
    localparam int LAT  = 3 + HALF + 9 * CPB + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rx_serial = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic [PW-1:0] rd_data;
    logic          frame_ready;
    logic          frame_ack = 1'b0;
    logic          busy;
    logic [AW-1:0] pix_count;
    logic          frame_err;

    always #5 clk = ~clk;

    uart_image_loader #(
        .CLKS_PER_BIT(CPB),
        .NUM_PIXELS  (N),
        .ADDR_W      (AW),
        .PIX_W       (PW),
        .IDLE_TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_serial  (rx_serial),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_ready(frame_ready),
        .frame_ack  (frame_ack),
        .busy       (busy),
        .pix_count  (pix_count),
        .frame_err  (frame_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         ok;
        bit         is_ack;
    } ev_t;
    ev_t ev_q[$];
    ev_t keep_q[$];

    logic [7:0] m_mem   [0:(1<<AW)-1];
    bit         m_known [0:(1<<AW)-1];
    bit         m_ready = 1'b0;
    int         m_count = 0;
    bit         m_err   = 1'b0;
    int         m_last  = 0;
    int         skip_until = -1;
    bit         skip;
    bit         exp_valid;
    logic [7:0] exp_rd;
    int         wr_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each transmitted byte becomes an event at its write edge; frame rules applied at that edge.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (!resetn) begin
            ev_q.delete();
            m_ready = 0; m_count = 0; m_err = 0; skip_until = -1;
            foreach (m_known[i]) m_known[i] = 1'b0;
            check("rst_rd_data", rd_data, 0);
            check("rst_frame_ready", frame_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_pix_count", pix_count, 0);
            check("rst_frame_err", frame_err, 0);
        end else begin
            exp_valid = m_known[rd_addr];
            exp_rd    = m_mem[rd_addr];
            wr_addr   = -1;
            foreach (ev_q[i]) begin
                if (ev_q[i].due == cyc && ev_q[i].is_ack && m_ready) begin
                    m_ready = 0; m_count = 0; m_err = 0;
                end
            end
            foreach (ev_q[i]) begin
                if (ev_q[i].due == cyc && !ev_q[i].is_ack) begin
                    if (!ev_q[i].ok) begin
                        m_err = 1;
                    end else begin
                        m_last = cyc;
                        if (!m_ready) begin
                            m_mem[m_count]   = ev_q[i].data;
                            m_known[m_count] = 1'b1;
                            wr_addr = m_count;
                            m_count++;
                            if (m_count == N) m_ready = 1;
                        end
                    end
                end
            end
            keep_q.delete();
            foreach (ev_q[i]) if (ev_q[i].due > cyc) keep_q.push_back(ev_q[i]);
            ev_q = keep_q;

            skip = 0;
            if (m_count != 0 && !m_ready && cyc >= m_last + T - 2) begin
                skip = 1;
                if (cyc >= m_last + T) begin
                    m_count = 0; m_err = 0; skip_until = cyc + 2;
                end
            end
            if (cyc <= skip_until) skip = 1;

            check("cmp_frame_ready", frame_ready, m_ready);
            if (!skip) begin
                check("cmp_pix_count", pix_count, m_count);
                check("cmp_busy", busy, (m_count != 0) && !m_ready);
                check("cmp_frame_err", frame_err, m_err);
            end
            if (exp_valid && wr_addr != int'(rd_addr)) check("cmp_rd_data", rd_data, exp_rd);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit good);
        ev_t e;
        @(negedge clk);
        e.due = cyc + LAT; e.data = b; e.ok = good; e.is_ack = 1'b0;
        ev_q.push_back(e);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = good;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic pulse_ack();
        ev_t e;
        frame_ack = 1'b1;
        e.due = cyc + 1; e.data = 8'h00; e.ok = 1'b0; e.is_ack = 1'b1;
        ev_q.push_back(e);
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic read_check(input string name, input int a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = AW'(a);
        @(posedge clk);
        #1;
        check(name, rd_data, exp);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rd_data", rd_data, 0);
        check("reset_pix_count", pix_count, 0);
        check("reset_frame_ready", frame_ready, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Short low glitch on an idle line.
        rx_serial = 1'b0;
        repeat ((CPB * 3) / 10) @(negedge clk);
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_pix_count", pix_count, 0);
        check("glitch_frame_err", frame_err, 0);

        // 0xA5 with a low stop bit, then the first frame.
        send_byte(8'hA5, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("badstop_frame_err", frame_err, 1);
        check("badstop_pix_count", pix_count, 0);
        for (int i = 0; i < N; i++) send_byte(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check("f1_frame_ready", frame_ready, 1);
        check("f1_busy", busy, 0);
        check("f1_pix_count", pix_count, N);
        check("f1_frame_err", frame_err, 1);
        read_check("f1_rd_0", 0, 8'h00);
        read_check("f1_rd_255", 255, 8'hFF);
        read_check("f1_rd_259", 259, 8'h03);

        // Bytes while the frame is held are dropped.
        for (int i = 0; i < 3; i++) send_byte(8'hEE, 1'b1);
        repeat (4) @(negedge clk);
        check("extra_pix_count", pix_count, N);
        read_check("extra_rd_0", 0, 8'h00);
        read_check("extra_rd_1", 1, 8'h01);
        @(negedge clk);
        pulse_ack();
        @(negedge clk);
        check("ack_frame_ready", frame_ready, 0);
        check("ack_pix_count", pix_count, 0);
        check("ack_frame_err", frame_err, 0);

        // Partial frame abandoned by the silence timeout.
        for (int i = 0; i < 20; i++) send_byte(8'h80 + 8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check("to_pix_count_before", pix_count, 20);
        check("to_busy_before", busy, 1);
        repeat (T + 20) @(negedge clk);
        check("to_pix_count_after", pix_count, 0);
        check("to_busy_after", busy, 0);
        read_check("to_rd_5", 5, 8'h85);

        for (int i = 0; i < N; i++) send_byte(8'(3 * i + 7), 1'b1);
        repeat (4) @(negedge clk);
        check("f2_frame_ready", frame_ready, 1);
        check("f2_pix_count", pix_count, N);
        read_check("f2_rd_1", 1, 8'h0A);
        read_check("f2_rd_100", 100, 8'h33);

        // Ack on the very edge the next byte is written.
        fork
            send_byte(8'h5A, 1'b1);
            begin
                @(negedge clk);
                repeat (LAT - 1) @(negedge clk);
                pulse_ack();
            end
        join
        repeat (2) @(negedge clk);
        check("coinc_pix_count", pix_count, 1);
        check("coinc_frame_ready", frame_ready, 0);
        check("coinc_busy", busy, 1);
        read_check("coinc_rd_0", 0, 8'h5A);

        // Reset in the middle of bit 4 of a byte.
        for (int i = 1; i < 10; i++) send_byte(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check("prerst_pix_count", pix_count, 10);
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_serial = i[0];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = 1'b1;
        repeat (HALF) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("async_rst_pix_count", pix_count, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_data", rd_data, 0);
        check("async_rst_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        for (int i = 0; i < N; i++) send_byte(8'(i) ^ 8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check("f3_frame_ready", frame_ready, 1);
        check("f3_pix_count", pix_count, N);
        check("f3_frame_err", frame_err, 0);
        read_check("f3_rd_0", 0, 8'h55);
        read_check("f3_rd_259", 259, 8'h56);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
